core_run_controller: RTL and testbench

CORE_RUN_CONTROLLER -- requirements
Module: core_run_controller

---
 rtl/kgp_ctrl_pkg.sv | 27 ++
 rtl/ld_word_packer.sv | 36 +++
 rtl/core_run_controller.sv | 171 +++++++++++++++++
 tb/tb_core_run_controller.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kgp_ctrl_pkg.sv
// Shared encodings for the core run controller: FSM states, command opcodes
// and halt causes.
package kgp_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_STEP = 3'd3,
        ST_HALT = 3'd4
    } ctrlState_t;

    typedef enum logic [1:0] {
        CMD_LOAD = 2'd0,
        CMD_RUN  = 2'd1,
        CMD_STEP = 2'd2,
        CMD_STOP = 2'd3
    } cmdOp_t;

    typedef enum logic [1:0] {
        HC_NONE   = 2'd0,
        HC_STOP   = 2'd1,
        HC_OPCODE = 2'd2,
        HC_BREAK  = 2'd3
    } haltCause_t;

endpackage

// File: rtl/ld_word_packer.sv
// Packs a stream of load bytes big-endian into 32-bit words and raises a
// one-cycle wordReady pulse the cycle after the fourth byte is taken.
module ld_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byteValid,
    input  logic [7:0]  byteData,
    output logic [31:0] word,
    output logic        wordReady
);

    logic [1:0]  byteCount;
    logic [31:0] shiftReg;

    // Byte counter and word-complete pulse; a clear drops any partial word.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            byteCount <= 2'd0;
            wordReady <= 1'b0;
        end else begin
            wordReady <= byteValid && (byteCount == 2'd3);
            if (byteValid)
                byteCount <= byteCount + 2'd1;
        end
    end

    // Shift left so the first byte of a word ends up in bits [31:24].
    always_ff @(posedge clk) begin
        if (byteValid)
            shiftReg <= {shiftReg[23:0], byteData};
    end

    assign word = shiftReg;

endmodule

// File: rtl/core_run_controller.sv
// Run controller for a small core: loads instruction memory from a byte
// stream, then runs, single-steps and halts the datapath on STOP, a halt
// opcode or a breakpoint.
module core_run_controller
    import kgp_ctrl_pkg::*;
#(
    parameter int          IMEM_WORDS  = 256,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_len,
    output logic        cmd_ready,
    output logic        cmd_err,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    output logic        ld_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    input  logic [31:0] instr_add,
    input  logic [31:0] instr,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    output logic        core_en,
    output logic        core_rst,
    output logic [2:0]  state,
    output logic [1:0]  halt_cause,
    output logic [31:0] cycle_count
);

    localparam logic [16:0] MAX_WORDS = 17'(IMEM_WORDS);

    ctrlState_t  curState, nextState;
    logic        haltHit, bpHit, bpSkip, inExec, cmdFire, lenBad;
    logic        loadStart, runFresh, resume, cmdErrNext;
    logic [1:0]  haltCauseNext;
    logic [15:0] wordIdx, lastIdx;
    logic        unusedInstrBits;

    function automatic logic [31:0] satInc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign unusedInstrBits = ^instr[25:0];

    assign haltHit   = (instr[31:26] == HALT_OPCODE);
    assign bpHit     = bp_en && (instr_add == bp_addr) && !bpSkip;
    assign inExec    = (curState == ST_RUN) || (curState == ST_STEP);
    assign core_en   = inExec && !haltHit && !bpHit;
    assign core_rst  = (curState == ST_IDLE) || (curState == ST_LOAD);
    assign ld_ready  = (curState == ST_LOAD) && !imem_we;
    assign cmdFire   = cmd_valid && cmd_ready;
    assign lenBad    = (cmd_len == 16'd0) || ({1'b0, cmd_len} > MAX_WORDS);
    assign imem_addr = {14'd0, wordIdx, 2'b00};
    assign state     = curState;

    ld_word_packer uPacker (
        .clk       (clk),
        .rst       (rst),
        .clear     (loadStart),
        .byteValid (ld_valid && ld_ready),
        .byteData  (ld_data),
        .word      (imem_wdata),
        .wordReady (imem_we)
    );

    // Command acceptance: any command while idle or halted, only STOP while running.
    always_comb begin
        cmd_ready = 1'b0;
        case (curState)
            ST_IDLE, ST_HALT: cmd_ready = 1'b1;
            ST_RUN:           cmd_ready = (cmdOp_t'(cmd_op) == CMD_STOP);
            default:          cmd_ready = 1'b0;
        endcase
    end

    // Next-state logic plus the one-shot control strobes that go with each transition.
    always_comb begin
        nextState     = curState;
        loadStart     = 1'b0;
        runFresh      = 1'b0;
        resume        = 1'b0;
        cmdErrNext    = 1'b0;
        haltCauseNext = halt_cause;
        case (curState)
            ST_IDLE, ST_HALT: begin
                if (cmdFire) begin
                    case (cmdOp_t'(cmd_op))
                        CMD_LOAD: begin
                            if (lenBad) begin
                                cmdErrNext = 1'b1;
                            end else begin
                                nextState = ST_LOAD;
                                loadStart = 1'b1;
                            end
                        end
                        CMD_RUN: begin
                            nextState = ST_RUN;
                            if (curState == ST_IDLE) runFresh = 1'b1;
                            else                     resume   = 1'b1;
                        end
                        CMD_STEP: begin
                            if (curState == ST_HALT) begin
                                nextState = ST_STEP;
                                resume    = 1'b1;
                            end else begin
                                cmdErrNext = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_LOAD: begin
                if (imem_we && (wordIdx == lastIdx))
                    nextState = ST_IDLE;
            end
            ST_RUN: begin
                if (haltHit) begin
                    nextState     = ST_HALT;
                    haltCauseNext = HC_OPCODE;
                end else if (bpHit) begin
                    nextState     = ST_HALT;
                    haltCauseNext = HC_BREAK;
                end else if (cmdFire) begin
                    nextState     = ST_HALT;
                    haltCauseNext = HC_STOP;
                end
            end
            ST_STEP: begin
                nextState = ST_HALT;
                if (haltHit) haltCauseNext = HC_OPCODE;
            end
            default: nextState = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) curState <= ST_IDLE;
        else     curState <= nextState;
    end

    // Control registers: reject pulse, halt cause, breakpoint skip, cycle counter, word index.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_err     <= 1'b0;
            halt_cause  <= HC_NONE;
            bpSkip      <= 1'b0;
            cycle_count <= 32'd0;
            wordIdx     <= 16'd0;
        end else begin
            cmd_err    <= cmdErrNext;
            halt_cause <= runFresh ? HC_NONE : haltCauseNext;
            bpSkip     <= resume;
            if (runFresh)     cycle_count <= 32'd0;
            else if (core_en) cycle_count <= satInc(cycle_count);
            if (loadStart)    wordIdx <= 16'd0;
            else if (imem_we) wordIdx <= wordIdx + 16'd1;
        end
    end

    // Index of the final word of the current load.
    always_ff @(posedge clk) begin
        if (loadStart) lastIdx <= cmd_len - 16'd1;
    end

endmodule

// File: tb/tb_core_run_controller.sv
// Bench for core_run_controller: a tiny PC model stands in for the datapath,
// and expected halt points, counts and memory writes come from the program
// layout and the byte stream.
module tb_core_run_controller;
    import kgp_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_len;
    logic        cmd_ready, cmd_err;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_ready;
    logic        imem_we;
    logic [31:0] imem_addr, imem_wdata;
    logic [31:0] instr_add, instr;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic        core_en, core_rst;
    logic [2:0]  state;
    logic [1:0]  halt_cause;
    logic [31:0] cycle_count;

    int checks = 0;
    int failures = 0;

    logic [31:0] prog [64];
    logic [31:0] pc = 32'd0;
    logic [31:0] wrAddr[$];
    logic [31:0] wrData[$];

    core_run_controller #(.IMEM_WORDS(256), .HALT_OPCODE(6'b111111)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_len(cmd_len),
        .cmd_ready(cmd_ready), .cmd_err(cmd_err), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .instr_add(instr_add), .instr(instr), .bp_en(bp_en), .bp_addr(bp_addr),
        .core_en(core_en), .core_rst(core_rst), .state(state), .halt_cause(halt_cause),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: PC held at 0 under core_rst, advances by 4 when enabled.
    always @(posedge clk) begin
        if (core_rst === 1'b1)     pc <= 32'd0;
        else if (core_en === 1'b1) pc <= pc + 32'd4;
    end
    assign instr_add = pc;
    assign instr     = prog[pc[7:2]];

    // Record every instruction-memory write.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wrAddr.push_back(imem_addr);
            wrData.push_back(imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendCmd(input logic [1:0] op, input logic [15:0] len);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic doReset();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        ld_valid  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Program of ordinary instructions with a single halt opcode at haltIdx.
    task automatic fillProg(input int haltIdx);
        for (int i = 0; i < 64; i++)
            prog[i] = {6'($urandom_range(0, 62)), 26'($urandom)};
        prog[haltIdx] = {6'h3F, 26'($urandom)};
    endtask

    task automatic feedBytes(input logic [7:0] bytes[$]);
        int g;
        foreach (bytes[i]) begin
            ld_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
            ld_valid = 1'b1;
            ld_data  = bytes[i];
            g = 0;
            while (ld_ready !== 1'b1 && g < 8) begin
                tick();
                g++;
            end
            tick();
        end
        ld_valid = 1'b0;
    endtask

    task automatic loadAndCheck(input string tag, input int len, input logic [7:0] bytes[$]);
        int g;
        logic [31:0] expWord;
        wrAddr.delete();
        wrData.delete();
        sendCmd(CMD_LOAD, 16'(len));
        check({tag, "_enter_load"}, 32'(state), 32'(ST_LOAD));
        check({tag, "_core_rst"}, 32'(core_rst), 32'd1);
        feedBytes(bytes);
        g = 0;
        while (state !== ST_IDLE && g < 10) begin
            tick();
            g++;
        end
        check({tag, "_back_idle"}, 32'(state), 32'(ST_IDLE));
        check({tag, "_nwrites"}, 32'(wrAddr.size()), 32'(len));
        for (int w = 0; w < len && w < wrAddr.size(); w++) begin
            expWord = 32'(bytes[4*w]) * 32'h0100_0000 + 32'(bytes[4*w+1]) * 32'h0001_0000
                    + 32'(bytes[4*w+2]) * 32'h0000_0100 + 32'(bytes[4*w+3]);
            check({tag, "_addr"}, wrAddr[w], 32'(w * 4));
            check({tag, "_data"}, wrData[w], expWord);
        end
    endtask

    task automatic waitHalt(input string tag);
        int n = 0;
        while (state !== ST_HALT && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_reached_halt"}, 32'(n < 300), 32'd1);
    endtask

    initial begin : stim
        logic [7:0] bytes[$];
        int len, n, haltIdx, bpIdx, bpOn, g;
        int stopIdx[$];
        int stopCause[$];

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_len = 16'd0;
        ld_valid = 1'b0; ld_data = 8'd0; bp_en = 1'b0; bp_addr = 32'd0;
        fillProg(63);

        // Reset values while rst is held.
        tick();
        tick();
        check("rst_state", 32'(state), 32'(ST_IDLE));
        check("rst_core_rst", 32'(core_rst), 32'd1);
        check("rst_core_en", 32'(core_en), 32'd0);
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_cmd_err", 32'(cmd_err), 32'd0);
        check("rst_ld_ready", 32'(ld_ready), 32'd0);
        check("rst_halt_cause", 32'(halt_cause), 32'd0);
        check("rst_cycle_count", cycle_count, 32'd0);
        rst = 1'b0;
        tick();
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        // STOP in IDLE is a no-op; STEP in IDLE is rejected.
        sendCmd(CMD_STOP, 16'd0);
        check("stop_idle_state", 32'(state), 32'(ST_IDLE));
        check("stop_idle_err", 32'(cmd_err), 32'd0);
        sendCmd(CMD_STEP, 16'd0);
        check("step_idle_err", 32'(cmd_err), 32'd1);
        check("step_idle_state", 32'(state), 32'(ST_IDLE));
        tick();
        check("step_idle_err_clear", 32'(cmd_err), 32'd0);

        // Directed two-word load.
        bytes = '{8'h20, 8'h00, 8'h00, 8'h05, 8'h8C, 8'h22, 8'h00, 8'h04};
        loadAndCheck("load2", 2, bytes);

        // Random loads.
        for (int it = 0; it < 3; it++) begin
            len = $urandom_range(1, 5);
            bytes.delete();
            for (int b = 0; b < 4 * len; b++) bytes.push_back(8'($urandom));
            loadAndCheck("load_rand", len, bytes);
        end

        // Out-of-range load lengths.
        wrAddr.delete();
        sendCmd(CMD_LOAD, 16'd300);
        check("len300_err", 32'(cmd_err), 32'd1);
        check("len300_state", 32'(state), 32'(ST_IDLE));
        tick();
        check("len300_err_pulse", 32'(cmd_err), 32'd0);
        sendCmd(CMD_LOAD, 16'd257);
        check("len257_err", 32'(cmd_err), 32'd1);
        sendCmd(CMD_LOAD, 16'd0);
        check("len0_err", 32'(cmd_err), 32'd1);
        check("len0_state", 32'(state), 32'(ST_IDLE));
        repeat (3) tick();
        check("badlen_no_write", 32'(wrAddr.size()), 32'd0);

        // Reset after the second byte of a load discards the partial word.
        wrAddr.delete();
        sendCmd(CMD_LOAD, 16'd1);
        bytes = '{8'hAA, 8'hBB};
        feedBytes(bytes);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midload_rst_state", 32'(state), 32'(ST_IDLE));
        check("midload_rst_core_rst", 32'(core_rst), 32'd1);
        repeat (4) tick();
        check("midload_rst_no_write", 32'(wrAddr.size()), 32'd0);

        // Halt opcode at PC 0x10.
        fillProg(4);
        bp_en = 1'b0;
        sendCmd(CMD_RUN, 16'd0);
        check("run_core_rst", 32'(core_rst), 32'd0);
        check("run_cmd_ready_run", 32'(cmd_ready), 32'd0);
        waitHalt("hop");
        check("hop_cause", 32'(halt_cause), 32'(HC_OPCODE));
        check("hop_count", cycle_count, 32'd4);
        check("hop_pc", pc, 32'h10);
        check("hop_core_en", 32'(core_en), 32'd0);

        // Breakpoint then single steps, last one onto the halt opcode.
        doReset();
        fillProg(5);
        bp_en = 1'b1;
        bp_addr = 32'h10;
        sendCmd(CMD_RUN, 16'd0);
        waitHalt("bp4");
        check("bp4_cause", 32'(halt_cause), 32'(HC_BREAK));
        check("bp4_pc", pc, 32'h10);
        check("bp4_count", cycle_count, 32'd4);
        sendCmd(CMD_STEP, 16'd0);
        check("step1_state", 32'(state), 32'(ST_STEP));
        check("step1_core_en", 32'(core_en), 32'd1);
        tick();
        check("step1_back_halt", 32'(state), 32'(ST_HALT));
        check("step1_pc", pc, 32'h14);
        check("step1_count", cycle_count, 32'd5);
        check("step1_cause", 32'(halt_cause), 32'(HC_BREAK));
        sendCmd(CMD_STEP, 16'd0);
        check("step2_core_en", 32'(core_en), 32'd0);
        tick();
        check("step2_back_halt", 32'(state), 32'(ST_HALT));
        check("step2_pc", pc, 32'h14);
        check("step2_count", cycle_count, 32'd5);
        check("step2_cause", 32'(halt_cause), 32'(HC_OPCODE));

        // LOAD from HALT, then a fresh RUN clears the counter and cause.
        sendCmd(CMD_LOAD, 16'd1);
        check("halt_load_state", 32'(state), 32'(ST_LOAD));
        check("halt_load_core_rst", 32'(core_rst), 32'd1);
        bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
        feedBytes(bytes);
        g = 0;
        while (state !== ST_IDLE && g < 10) begin
            tick();
            g++;
        end
        check("halt_load_idle", 32'(state), 32'(ST_IDLE));
        bp_en = 1'b0;
        sendCmd(CMD_RUN, 16'd0);
        check("fresh_run_cause", 32'(halt_cause), 32'(HC_NONE));
        check("fresh_run_count", cycle_count, 32'd0);
        waitHalt("fresh");
        check("fresh_count", cycle_count, 32'd5);

        // STOP in the same cycle as a halt opcode: opcode wins.
        doReset();
        fillProg(3);
        sendCmd(CMD_RUN, 16'd0);
        g = 0;
        while (pc !== 32'hC && g < 20) begin
            tick();
            g++;
        end
        cmd_valid = 1'b1;
        cmd_op    = CMD_STOP;
        #1;
        check("run_cmd_ready_stop", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        check("stop_hop_state", 32'(state), 32'(ST_HALT));
        check("stop_hop_cause", 32'(halt_cause), 32'(HC_OPCODE));
        check("stop_hop_count", cycle_count, 32'd3);

        // Plain STOP after a random number of cycles, then resume to the halt opcode.
        doReset();
        fillProg(40);
        sendCmd(CMD_RUN, 16'd0);
        n = $urandom_range(2, 12);
        repeat (n) tick();
        sendCmd(CMD_STOP, 16'd0);
        check("stop_state", 32'(state), 32'(ST_HALT));
        check("stop_cause", 32'(halt_cause), 32'(HC_STOP));
        check("stop_count", cycle_count, 32'(n + 1));
        sendCmd(CMD_STOP, 16'd0);
        check("stop_in_halt_noop", 32'(state), 32'(ST_HALT));
        sendCmd(CMD_RUN, 16'd0);
        waitHalt("resume40");
        check("resume40_count", cycle_count, 32'd40);
        check("resume40_cause", 32'(halt_cause), 32'(HC_OPCODE));

        // Randomized programs: expected stops from halt/breakpoint positions.
        for (int it = 0; it < 6; it++) begin
            doReset();
            haltIdx = $urandom_range(2, 30);
            bpIdx   = $urandom_range(0, 30);
            bpOn    = $urandom_range(0, 1);
            fillProg(haltIdx);
            bp_en   = bpOn[0];
            bp_addr = 32'(bpIdx * 4);
            stopIdx.delete();
            stopCause.delete();
            if (bpOn == 1 && bpIdx < haltIdx) begin
                stopIdx.push_back(bpIdx);
                stopCause.push_back(3);
            end
            stopIdx.push_back(haltIdx);
            stopCause.push_back(2);
            foreach (stopIdx[s]) begin
                sendCmd(CMD_RUN, 16'd0);
                waitHalt("rand");
                check("rand_pc", pc, 32'(stopIdx[s] * 4));
                check("rand_cause", 32'(halt_cause), 32'(stopCause[s]));
                check("rand_count", cycle_count, 32'(stopIdx[s]));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
